multicycle_main_controller: RTL and testbench

//  Main control FSM for the multicycle RV32I core; replaces the single-cycle opcode decoder.

---
 rtl/riscv_ctrl_pkg.sv | 86 ++++++++
 rtl/multicycle_main_controller_mem_wait_timer.sv | 43 ++++
 rtl/multicycle_main_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_main_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path.
// Holds the opcode constants, the main FSM state enum (4-bit, also exported on
// state_dbg) and the encodings of every datapath mux select and ALU/immediate
// control field. Used by the controller, the datapath and the bench.
package riscv_ctrl_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Main FSM states. lui and auipc share S_UTYPE so that all sixteen
    // encodings fit in four bits; the two differ only in the ALU A source.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXECR     = 4'd6,
        S_EXECI     = 4'd7,
        S_ALUWB     = 4'd8,
        S_BEQ       = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_JALR_LINK = 4'd12,
        S_UTYPE     = 4'd13,
        S_ILLEGAL   = 4'd14,
        S_BUSERR    = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10,
        SRCA_ZERO  = 2'b11
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_RDATA  = 2'b01,
        RES_ALU    = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    // Immediate format for an opcode; unknown opcodes fall back to I-type.
    function automatic imm_src_t imm_src_for(input logic [6:0] op);
        imm_src_t f;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: f = IMM_I;
            OP_STORE:                 f = IMM_S;
            OP_BRANCH:                f = IMM_B;
            OP_JAL:                   f = IMM_J;
            OP_LUI, OP_AUIPC:         f = IMM_U;
            default:                  f = IMM_I;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/multicycle_main_controller_mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on mem_ready and flags a bus
// timeout.
//   clk        clock
//   rst        synchronous active-high reset, clears the count
//   waiting    controller is in a memory-request state
//   mem_ready  memory completes the request this cycle
//   clear      controller changes state this cycle; restarts the count
//   timeout    count has reached TIMEOUT_CYCLES and mem_ready is still low
// TIMEOUT_CYCLES = 0 disables detection (timeout tied low).
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic mem_ready,
    input  logic clear,
    output logic timeout
);

    localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // The count never passes TIMEOUT_CYCLES: reaching it forces a state
    // change (advance or bus error), and every state change clears it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (waiting && !mem_ready) begin
            count <= count + 1'b1;
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign timeout = 1'b0;
        end else begin : g_timeout
            assign timeout = waiting && !mem_ready && (count == CW'(TIMEOUT_CYCLES));
        end
    endgenerate

endmodule

// File: rtl/multicycle_main_controller.sv
// multicycle_main_controller: main control FSM of the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback over a shared ALU and a
// single memory port, waits on mem_ready, traps unsupported opcodes and
// detects memory timeouts.
//   clk, rst     clock; synchronous active-high reset
//   op           opcode from the IR (stable from DECODE until next FETCH)
//   mem_ready    memory completes the current request this cycle
//   mem_req, mem_write, ir_write, pc_update, branch, reg_write
//                datapath enables (all forced low while rst is high)
//   adr_src, alu_src_a, alu_src_b, result_src, alu_op, imm_src
//                datapath mux selects / ALU and immediate control
//   instr_done   one-cycle pulse on the last cycle of each instruction
//   illegal      unsupported opcode trapped
//   bus_error    memory timeout, held until rst
//   state_dbg    current state encoding
module multicycle_main_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned SUPPORT_JALR    = 1,
    parameter int unsigned SUPPORT_UTYPE   = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 15,
    parameter int unsigned HALT_ON_ILLEGAL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_update,
    output logic       branch,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_error,
    output logic [3:0] state_dbg
);

    state_t state;
    state_t state_next;

    logic waiting;
    logic timeout;
    logic state_change;

    // Ungated enables; rst masks them at the ports.
    logic req_s;
    logic wr_s;
    logic irw_s;
    logic pcu_s;
    logic br_s;
    logic rw_s;
    logic done_s;

    assign waiting      = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign state_change = (state_next != state);

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .waiting   (waiting),
        .mem_ready (mem_ready),
        .clear     (state_change),
        .timeout   (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_BUSERR;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_IMM:            state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = (SUPPORT_JALR != 0) ? S_JALR : S_ILLEGAL;
                    OP_LUI, OP_AUIPC:  state_next = (SUPPORT_UTYPE != 0) ? S_UTYPE : S_ILLEGAL;
                    default:           state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:    state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timeout) begin
                    state_next = S_BUSERR;
                end
            end
            S_MEMWB:     state_next = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (timeout) begin
                    state_next = S_BUSERR;
                end
            end
            S_EXECR:     state_next = S_ALUWB;
            S_EXECI:     state_next = S_ALUWB;
            S_ALUWB:     state_next = S_FETCH;
            S_BEQ:       state_next = S_FETCH;
            S_JAL:       state_next = S_ALUWB;
            S_JALR:      state_next = S_JALR_LINK;
            S_JALR_LINK: state_next = S_ALUWB;
            S_UTYPE:     state_next = S_ALUWB;
            S_ILLEGAL: begin
                if (HALT_ON_ILLEGAL == 0) begin
                    state_next = S_FETCH;
                end
            end
            S_BUSERR:    state_next = S_BUSERR;
            default:     state_next = S_FETCH;
        endcase
    end

    // Moore outputs; only FETCH/MEMWRITE look at mem_ready.
    always_comb begin
        req_s      = 1'b0;
        wr_s       = 1'b0;
        irw_s      = 1'b0;
        pcu_s      = 1'b0;
        br_s       = 1'b0;
        rw_s       = 1'b0;
        done_s     = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                req_s      = 1'b1;
                irw_s      = mem_ready;
                pcu_s      = mem_ready;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                req_s   = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                rw_s       = 1'b1;
                done_s     = 1'b1;
            end
            S_MEMWRITE: begin
                req_s   = 1'b1;
                wr_s    = 1'b1;
                adr_src = 1'b1;
                done_s  = mem_ready;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                rw_s   = 1'b1;
                done_s = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_SUB;
                br_s      = 1'b1;
                done_s    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pcu_s     = 1'b1;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                pcu_s      = 1'b1;
            end
            S_JALR_LINK: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
            end
            S_UTYPE: begin
                // lui (op[5]=1) adds imm to zero; auipc (op[5]=0) to old_pc.
                alu_src_a = op[5] ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            default: begin
            end
        endcase
    end

    assign mem_req    = req_s  & ~rst;
    assign mem_write  = wr_s   & ~rst;
    assign ir_write   = irw_s  & ~rst;
    assign pc_update  = pcu_s  & ~rst;
    assign branch     = br_s   & ~rst;
    assign reg_write  = rw_s   & ~rst;
    assign instr_done = done_s & ~rst;

    assign imm_src   = imm_src_for(op);
    assign illegal   = (state == S_ILLEGAL);
    assign bus_error = (state == S_BUSERR);
    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_main_controller.sv
module tb_multicycle_main_controller;
    import riscv_ctrl_pkg::*;

    // Observed vector: state, enables {mem_req,mem_write,ir_write,pc_update,
    // branch,reg_write,adr_src}, a, b, result_src, alu_op, imm_src,
    // {instr_done,illegal,bus_error}, wait count.
    typedef struct packed {
        logic [3:0] st;
        logic [6:0] en;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] rs;
        logic [1:0] aop;
        logic [2:0] imm;
        logic [2:0] flg;
        logic [3:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: defaults. DUT B: no jalr/U-type, short timeout, illegal pulses.
    logic       rst_a, rdy_a, rst_b, rdy_b;
    logic [6:0] op_a, op_b;
    logic       req_a, wr_a, irw_a, pcu_a, br_a, rw_a, adr_a, done_a, ill_a, berr_a;
    logic       req_b, wr_b, irw_b, pcu_b, br_b, rw_b, adr_b, done_b, ill_b, berr_b;
    logic [1:0] sa_a, sb_a, rs_a, aop_a, sa_b, sb_b, rs_b, aop_b;
    logic [2:0] imm_a, imm_b;
    logic [3:0] sd_a, sd_b;

    multicycle_main_controller #(
        .SUPPORT_JALR(1), .SUPPORT_UTYPE(1), .TIMEOUT_CYCLES(15), .HALT_ON_ILLEGAL(1)
    ) dut_a (
        .clk(clk), .rst(rst_a), .op(op_a), .mem_ready(rdy_a),
        .mem_req(req_a), .mem_write(wr_a), .ir_write(irw_a), .pc_update(pcu_a),
        .branch(br_a), .reg_write(rw_a), .adr_src(adr_a), .alu_src_a(sa_a),
        .alu_src_b(sb_a), .result_src(rs_a), .alu_op(aop_a), .imm_src(imm_a),
        .instr_done(done_a), .illegal(ill_a), .bus_error(berr_a), .state_dbg(sd_a)
    );

    multicycle_main_controller #(
        .SUPPORT_JALR(0), .SUPPORT_UTYPE(0), .TIMEOUT_CYCLES(3), .HALT_ON_ILLEGAL(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .op(op_b), .mem_ready(rdy_b),
        .mem_req(req_b), .mem_write(wr_b), .ir_write(irw_b), .pc_update(pcu_b),
        .branch(br_b), .reg_write(rw_b), .adr_src(adr_b), .alu_src_a(sa_b),
        .alu_src_b(sb_b), .result_src(rs_b), .alu_op(aop_b), .imm_src(imm_b),
        .instr_done(done_b), .illegal(ill_b), .bus_error(berr_b), .state_dbg(sd_b)
    );

    obs_t act_a, act_b;
    assign act_a = {sd_a, req_a, wr_a, irw_a, pcu_a, br_a, rw_a, adr_a, sa_a, sb_a, rs_a, aop_a,
                    imm_a, done_a, ill_a, berr_a, 4'(dut_a.u_timer.count)};
    assign act_b = {sd_b, req_b, wr_b, irw_b, pcu_b, br_b, rw_b, adr_b, sa_b, sb_b, rs_b, aop_b,
                    imm_b, done_b, ill_b, berr_b, 4'(dut_b.u_timer.count)};

    obs_t  qa[$], qb[$];
    string na[$], nb[$];
    int    checks = 0;
    int    errors = 0;

    function automatic obs_t mk(input state_t st, input logic [6:0] en, input logic [1:0] a,
                                input logic [1:0] b, input logic [1:0] rs, input logic [1:0] aop,
                                input logic [2:0] imm, input logic [2:0] flg, input logic [3:0] cnt);
        obs_t o;
        o.st = st; o.en = en; o.a = a; o.b = b; o.rs = rs; o.aop = aop;
        o.imm = imm; o.flg = flg; o.cnt = cnt;
        return o;
    endfunction

    // Drive one cycle of inputs on the selected DUT and queue its expected outputs.
    task automatic cyc(input bit sel, input string nm, input logic r, input logic [6:0] o,
                       input logic rdy, input obs_t e);
        if (sel) begin
            rst_b = r; op_b = o; rdy_b = rdy; qb.push_back(e); nb.push_back(nm);
        end else begin
            rst_a = r; op_a = o; rdy_a = rdy; qa.push_back(e); na.push_back(nm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input bit sel, input string nm, input logic [6:0] o, input logic [2:0] imm);
        cyc(sel, {nm, "_fetch"}, 1'b0, o, 1'b1,
            mk(S_FETCH, 7'b1011000, 2'b00, 2'b10, 2'b10, 2'b00, imm, 3'b000, 4'd0));
    endtask

    task automatic decode(input bit sel, input string nm, input logic [6:0] o, input logic [2:0] imm);
        cyc(sel, {nm, "_decode"}, 1'b0, o, 1'b1,
            mk(S_DECODE, 7'b0000000, 2'b01, 2'b01, 2'b00, 2'b00, imm, 3'b000, 4'd0));
    endtask

    task automatic aluwb(input bit sel, input string nm, input logic [6:0] o, input logic [2:0] imm);
        cyc(sel, {nm, "_aluwb"}, 1'b0, o, 1'b1,
            mk(S_ALUWB, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, imm, 3'b100, 4'd0));
    endtask

    // Monitor: compare each presented cycle against the head of its queue.
    initial begin
        obs_t  e;
        string n;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front(); n = na.pop_front();
                checks++;
                if (act_a !== e) begin
                    errors++;
                    $display("FAIL %s: dut_a got %h required %h (state %0d vs %0d)", n, act_a, e, act_a.st, e.st);
                end
            end
            if (qb.size() > 0) begin
                e = qb.pop_front(); n = nb.pop_front();
                checks++;
                if (act_b !== e) begin
                    errors++;
                    $display("FAIL %s: dut_b got %h required %h (state %0d vs %0d)", n, act_b, e, act_b.st, e.st);
                end
            end
        end
    end

    initial begin
        rst_a = 1'b1; op_a = 7'h00; rdy_a = 1'b1;
        rst_b = 1'b1; op_b = 7'h00; rdy_b = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- DUT A ----------------
        cyc(0, "a_rst", 1'b1, 7'h00, 1'b1,
            mk(S_FETCH, 7'b0000000, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 3'b000, 4'd0));

        // lw: 5 cycles
        fetch(0, "lw", OP_LOAD, 3'b000);
        decode(0, "lw", OP_LOAD, 3'b000);
        cyc(0, "lw_memadr", 1'b0, OP_LOAD, 1'b1,
            mk(S_MEMADR, 7'b0000000, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 4'd0));
        cyc(0, "lw_memread", 1'b0, OP_LOAD, 1'b1,
            mk(S_MEMREAD, 7'b1000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 4'd0));
        cyc(0, "lw_memwb", 1'b0, OP_LOAD, 1'b1,
            mk(S_MEMWB, 7'b0000010, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 3'b100, 4'd0));

        // sw with three wait cycles
        fetch(0, "sw", OP_STORE, 3'b001);
        decode(0, "sw", OP_STORE, 3'b001);
        cyc(0, "sw_memadr", 1'b0, OP_STORE, 1'b1,
            mk(S_MEMADR, 7'b0000000, 2'b10, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000, 4'd0));
        for (int unsigned i = 0; i < 3; i++) begin
            cyc(0, "sw_wait", 1'b0, OP_STORE, 1'b0,
                mk(S_MEMWRITE, 7'b1100001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 4'(i)));
        end
        cyc(0, "sw_done", 1'b0, OP_STORE, 1'b1,
            mk(S_MEMWRITE, 7'b1100001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 3'b100, 4'd3));

        // jalr (fetch also shows the wait count cleared)
        fetch(0, "jalr", OP_JALR, 3'b000);
        decode(0, "jalr", OP_JALR, 3'b000);
        cyc(0, "jalr_exec", 1'b0, OP_JALR, 1'b1,
            mk(S_JALR, 7'b0001000, 2'b10, 2'b01, 2'b10, 2'b00, 3'b000, 3'b000, 4'd0));
        cyc(0, "jalr_link", 1'b0, OP_JALR, 1'b1,
            mk(S_JALR_LINK, 7'b0000000, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 4'd0));
        aluwb(0, "jalr", OP_JALR, 3'b000);

        // R-type and I-type
        fetch(0, "r", OP_R, 3'b000);
        decode(0, "r", OP_R, 3'b000);
        cyc(0, "r_exec", 1'b0, OP_R, 1'b1,
            mk(S_EXECR, 7'b0000000, 2'b10, 2'b00, 2'b00, 2'b10, 3'b000, 3'b000, 4'd0));
        aluwb(0, "r", OP_R, 3'b000);
        fetch(0, "i", OP_IMM, 3'b000);
        decode(0, "i", OP_IMM, 3'b000);
        cyc(0, "i_exec", 1'b0, OP_IMM, 1'b1,
            mk(S_EXECI, 7'b0000000, 2'b10, 2'b01, 2'b00, 2'b10, 3'b000, 3'b000, 4'd0));
        aluwb(0, "i", OP_IMM, 3'b000);

        // beq: 3 cycles
        fetch(0, "beq", OP_BRANCH, 3'b010);
        decode(0, "beq", OP_BRANCH, 3'b010);
        cyc(0, "beq_exec", 1'b0, OP_BRANCH, 1'b1,
            mk(S_BEQ, 7'b0000100, 2'b10, 2'b00, 2'b00, 2'b01, 3'b010, 3'b100, 4'd0));

        // jal
        fetch(0, "jal", OP_JAL, 3'b011);
        decode(0, "jal", OP_JAL, 3'b011);
        cyc(0, "jal_exec", 1'b0, OP_JAL, 1'b1,
            mk(S_JAL, 7'b0001000, 2'b01, 2'b10, 2'b00, 2'b00, 3'b011, 3'b000, 4'd0));
        aluwb(0, "jal", OP_JAL, 3'b011);

        // lui / auipc
        fetch(0, "lui", OP_LUI, 3'b100);
        decode(0, "lui", OP_LUI, 3'b100);
        cyc(0, "lui_exec", 1'b0, OP_LUI, 1'b1,
            mk(S_UTYPE, 7'b0000000, 2'b11, 2'b01, 2'b00, 2'b00, 3'b100, 3'b000, 4'd0));
        aluwb(0, "lui", OP_LUI, 3'b100);
        fetch(0, "auipc", OP_AUIPC, 3'b100);
        decode(0, "auipc", OP_AUIPC, 3'b100);
        cyc(0, "auipc_exec", 1'b0, OP_AUIPC, 1'b1,
            mk(S_UTYPE, 7'b0000000, 2'b01, 2'b01, 2'b00, 2'b00, 3'b100, 3'b000, 4'd0));
        aluwb(0, "auipc", OP_AUIPC, 3'b100);

        // illegal opcode halts until reset
        fetch(0, "a_ill", 7'b1111111, 3'b000);
        decode(0, "a_ill", 7'b1111111, 3'b000);
        for (int unsigned i = 0; i < 3; i++) begin
            cyc(0, "a_ill_halt", 1'b0, 7'b1111111, 1'b1,
                mk(S_ILLEGAL, 7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b010, 4'd0));
        end
        cyc(0, "a_ill_rst", 1'b1, 7'b1111111, 1'b1,
            mk(S_ILLEGAL, 7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b010, 4'd0));
        fetch(0, "a_after_rst", OP_R, 3'b000);
        rst_a = 1'b1;

        // ---------------- DUT B ----------------
        cyc(1, "b_rst", 1'b1, 7'h00, 1'b1,
            mk(S_FETCH, 7'b0000000, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 3'b000, 4'd0));

        // jalr unsupported -> one-cycle illegal, then fetch
        fetch(1, "b_jalr", OP_JALR, 3'b000);
        decode(1, "b_jalr", OP_JALR, 3'b000);
        cyc(1, "b_jalr_ill", 1'b0, OP_JALR, 1'b1,
            mk(S_ILLEGAL, 7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b010, 4'd0));
        fetch(1, "b_bad", 7'b1111111, 3'b000);
        decode(1, "b_bad", 7'b1111111, 3'b000);
        cyc(1, "b_bad_ill", 1'b0, 7'b1111111, 1'b1,
            mk(S_ILLEGAL, 7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b010, 4'd0));
        fetch(1, "b_lui", OP_LUI, 3'b100);
        decode(1, "b_lui", OP_LUI, 3'b100);
        cyc(1, "b_lui_ill", 1'b0, OP_LUI, 1'b1,
            mk(S_ILLEGAL, 7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100, 3'b010, 4'd0));

        // mem_ready arrives on the 4th wait cycle: no error
        for (int unsigned i = 0; i < 3; i++) begin
            cyc(1, "b_fetch_wait", 1'b0, OP_R, 1'b0,
                mk(S_FETCH, 7'b1000000, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 3'b000, 4'(i)));
        end
        cyc(1, "b_fetch_late", 1'b0, OP_R, 1'b1,
            mk(S_FETCH, 7'b1011000, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 3'b000, 4'd3));
        decode(1, "b_r", OP_R, 3'b000);
        cyc(1, "b_r_exec", 1'b0, OP_R, 1'b1,
            mk(S_EXECR, 7'b0000000, 2'b10, 2'b00, 2'b00, 2'b10, 3'b000, 3'b000, 4'd0));
        aluwb(1, "b_r", OP_R, 3'b000);

        // four cycles without mem_ready -> bus error, held until reset
        for (int unsigned i = 0; i < 4; i++) begin
            cyc(1, "b_to_wait", 1'b0, OP_R, 1'b0,
                mk(S_FETCH, 7'b1000000, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 3'b000, 4'(i)));
        end
        for (int unsigned i = 0; i < 3; i++) begin
            cyc(1, "b_buserr", 1'b0, OP_R, 1'b1,
                mk(S_BUSERR, 7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 4'd0));
        end
        cyc(1, "b_buserr_rst", 1'b1, OP_R, 1'b1,
            mk(S_BUSERR, 7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 4'd0));
        fetch(1, "b_after_rst", OP_R, 3'b000);
        rst_b = 1'b1;

        @(negedge clk);
        #1;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
